// File: rtl/qeciphy_pchannel_ctrl.sv
// P-channel initiator for QECIPHY: sequences the PSTATE/PREQ/PACCEPT four-phase
// handshake, with optional PACTIVE auto-wake and a sticky handshake timeout flag.
module qeciphy_pchannel_ctrl #(
    parameter logic RESET_PSTATE   = 1'b0,
    parameter int   AUTO_WAKE      = 1,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic ACLK,
    input  logic ARST,
    input  logic req_valid,
    input  logic req_state,
    output logic req_ready,
    output logic done,
    output logic cur_state,
    output logic busy,
    output logic timeout_err,
    input  logic err_clr,
    output logic PSTATE,
    output logic PREQ,
    input  logic PACCEPT,
    input  logic PACTIVE
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           state_q;
    logic             pstate_q;
    logic             preq_q;
    logic             cur_state_q;
    logic             done_q;
    logic             busy_q;
    logic             timeout_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             wake_req;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_inc;

    // Auto-wake only fires when no external request competes for the same cycle.
    assign wake_req    = (AUTO_WAKE != 0) && !cur_state_q && PACTIVE && !req_valid;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q       <= ST_IDLE;
            pstate_q      <= RESET_PSTATE;
            preq_q        <= 1'b0;
            cur_state_q   <= RESET_PSTATE;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_state != cur_state_q) begin
                            pstate_q <= req_state;
                            preq_q   <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= ST_REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else if (wake_req) begin
                        pstate_q <= 1'b1;
                        preq_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_inc;
                    // PREQ is only ever withdrawn after the responder accepts.
                    if (PACCEPT) begin
                        preq_q  <= 1'b0;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    cnt_q <= cnt_inc;
                    if (!PACCEPT) begin
                        cur_state_q <= pstate_q;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign done        = done_q;
    assign cur_state   = cur_state_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign PSTATE      = pstate_q;
    assign PREQ        = preq_q;

endmodule

// File: tb/tb_qeciphy_pchannel_ctrl.sv
// Self-checking bench for qeciphy_pchannel_ctrl: scenario tasks plus a done-pulse
// scoreboard that checks completion cycle and resulting power state.
module tb_qeciphy_pchannel_ctrl;

    logic ACLK = 1'b0;
    logic ARST;
    logic req_valid;
    logic req_state;
    logic req_ready;
    logic done;
    logic cur_state;
    logic busy;
    logic timeout_err;
    logic err_clr;
    logic PSTATE;
    logic PREQ;
    logic PACCEPT = 1'b0;
    logic PACTIVE;

    qeciphy_pchannel_ctrl #(
        .RESET_PSTATE  (1'b0),
        .AUTO_WAKE     (1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .req_valid  (req_valid),
        .req_state  (req_state),
        .req_ready  (req_ready),
        .done       (done),
        .cur_state  (cur_state),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_clr    (err_clr),
        .PSTATE     (PSTATE),
        .PREQ       (PREQ),
        .PACCEPT    (PACCEPT),
        .PACTIVE    (PACTIVE)
    );

    initial forever #5 ACLK = ~ACLK;

    typedef struct {
        int   due;
        logic state;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    // Responder model: either follows PREQ with programmable delays or holds a manual level.
    bit   resp_en    = 1'b0;
    logic man_accept = 1'b0;
    int   rise_dly   = 1;
    int   fall_dly   = 1;

    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        int hi_cnt;
        int lo_cnt;
        hi_cnt = 0;
        lo_cnt = 0;
        forever begin
            @(posedge ACLK);
            #2;
            if (!resp_en) begin
                PACCEPT = man_accept;
                hi_cnt  = 0;
                lo_cnt  = 0;
            end else if (PREQ === 1'b1) begin
                lo_cnt = 0;
                hi_cnt++;
                if (hi_cnt == rise_dly + 1) PACCEPT = 1'b1;
            end else begin
                hi_cnt = 0;
                if (PACCEPT) begin
                    lo_cnt++;
                    if (lo_cnt == fall_dly + 1) PACCEPT = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every done pulse must match the oldest pending transaction.
    initial begin
        exp_t e;
        forever begin
            @(posedge ACLK);
            #3;
            if (done === 1'b1) begin
                n_total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected_done: done at cycle %0d, required no pending done", cyc);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn done: state=%b cycle=%0d (expected state=%b cycle=%0d)", cur_state, cyc, e.state, e.due);
                    if (cur_state !== e.state || cyc != e.due)
                        $display("FAIL sb_done: got state=%b cycle=%0d, required state=%b cycle=%0d", cur_state, cyc, e.state, e.due);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push_exp(input int due, input logic st);
        exp_t e;
        e.due   = due;
        e.state = st;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_total++; if (PREQ !== 1'b0) $display("FAIL rst_preq: got %b required 0", PREQ); else n_pass++;
        n_total++; if (PSTATE !== 1'b0) $display("FAIL rst_pstate: got %b required 0", PSTATE); else n_pass++;
        n_total++; if (cur_state !== 1'b0) $display("FAIL rst_cur_state: got %b required 0", cur_state); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b required 0", timeout_err); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b required 1", req_ready); else n_pass++;
        tick();
        n_total++; if (PREQ !== 1'b0) $display("FAIL rst_idle_preq: got %b required 0", PREQ); else n_pass++;
    endtask

    task automatic test_basic_run();
        bit ok;
        rise_dly = 2;
        fall_dly = 1;
        resp_en  = 1'b1;
        req_valid = 1'b1;
        req_state = 1'b1;
        tick();
        req_valid = 1'b0;
        push_exp(cyc + 5, 1'b1);
        n_total++; if (PSTATE !== 1'b1) $display("FAIL basic_pstate: got %b required 1", PSTATE); else n_pass++;
        n_total++; if (PREQ !== 1'b1) $display("FAIL basic_preq: got %b required 1", PREQ); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL basic_req_ready: got %b required 0", req_ready); else n_pass++;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_total++; if (PREQ !== 1'b1) $display("FAIL basic_preq_hold%0d: got %b required 1", i, PREQ); else n_pass++;
        end
        tick();
        n_total++; if (PREQ !== 1'b0) $display("FAIL basic_preq_drop: got %b required 0", PREQ); else n_pass++;
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL basic_done_wait: got no done, required done within 20 cycles"); else n_pass++;
        n_total++; if (cur_state !== 1'b1) $display("FAIL basic_cur_state: got %b required 1", cur_state); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b required 0", busy); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL basic_ready_end: got %b required 1", req_ready); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL basic_done_single: got %b required 0", done); else n_pass++;
    endtask

    task automatic test_noop();
        req_valid = 1'b1;
        req_state = 1'b1;
        tick();
        req_valid = 1'b0;
        push_exp(cyc, 1'b1);
        n_total++; if (done !== 1'b1) $display("FAIL noop_done: got %b required 1", done); else n_pass++;
        n_total++; if (PREQ !== 1'b0) $display("FAIL noop_preq: got %b required 0", PREQ); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL noop_busy: got %b required 0", busy); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL noop_done_end: got %b required 0", done); else n_pass++;
        n_total++; if (PREQ !== 1'b0) $display("FAIL noop_preq_end: got %b required 0", PREQ); else n_pass++;
    endtask

    task automatic test_auto_wake();
        bit ok;
        rise_dly = 1;
        fall_dly = 1;
        resp_en  = 1'b1;
        // Drop to STOP with the minimum-latency responder.
        req_valid = 1'b1;
        req_state = 1'b0;
        tick();
        req_valid = 1'b0;
        push_exp(cyc + 4, 1'b0);
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL aw_stop_wait: got no done, required done"); else n_pass++;
        n_total++; if (cur_state !== 1'b0) $display("FAIL aw_stop_state: got %b required 0", cur_state); else n_pass++;
        PACTIVE = 1'b1;
        tick();
        PACTIVE = 1'b0;
        push_exp(cyc + 4, 1'b1);
        n_total++; if (PREQ !== 1'b1) $display("FAIL aw_preq: got %b required 1", PREQ); else n_pass++;
        n_total++; if (PSTATE !== 1'b1) $display("FAIL aw_pstate: got %b required 1", PSTATE); else n_pass++;
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL aw_wait: got no done, required done"); else n_pass++;
        n_total++; if (cur_state !== 1'b1) $display("FAIL aw_state: got %b required 1", cur_state); else n_pass++;
        // Back to STOP, then an external no-op races auto-wake.
        req_valid = 1'b1;
        req_state = 1'b0;
        tick();
        req_valid = 1'b0;
        push_exp(cyc + 4, 1'b0);
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL aw_stop2_wait: got no done, required done"); else n_pass++;
        req_valid = 1'b1;
        req_state = 1'b0;
        PACTIVE   = 1'b1;
        tick();
        req_valid = 1'b0;
        push_exp(cyc, 1'b0);
        n_total++; if (done !== 1'b1) $display("FAIL aw_conflict_done: got %b required 1", done); else n_pass++;
        n_total++; if (PREQ !== 1'b0) $display("FAIL aw_conflict_preq: got %b required 0", PREQ); else n_pass++;
        tick();
        PACTIVE = 1'b0;
        push_exp(cyc + 4, 1'b1);
        n_total++; if (PREQ !== 1'b1) $display("FAIL aw_follow_preq: got %b required 1", PREQ); else n_pass++;
        n_total++; if (PSTATE !== 1'b1) $display("FAIL aw_follow_pstate: got %b required 1", PSTATE); else n_pass++;
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL aw_follow_wait: got no done, required done"); else n_pass++;
        n_total++; if (cur_state !== 1'b1) $display("FAIL aw_follow_state: got %b required 1", cur_state); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        resp_en    = 1'b0;
        man_accept = 1'b0;
        req_valid  = 1'b1;
        req_state  = 1'b0;
        tick();
        req_valid = 1'b0;
        n_total++; if (PREQ !== 1'b1) $display("FAIL to_preq: got %b required 1", PREQ); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_total++; if (timeout_err !== 1'b0) $display("FAIL to_early%0d: got %b required 0", k, timeout_err); else n_pass++;
        end
        tick();
        n_total++; if (timeout_err !== 1'b1) $display("FAIL to_flag: got %b required 1", timeout_err); else n_pass++;
        n_total++; if (PREQ !== 1'b1) $display("FAIL to_preq_at_flag: got %b required 1", PREQ); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (PREQ !== 1'b1) $display("FAIL to_preq_hold%0d: got %b required 1", k, PREQ); else n_pass++;
        end
        man_accept = 1'b1;
        push_exp(cyc + 2, 1'b0);
        tick();
        n_total++; if (PREQ !== 1'b0) $display("FAIL to_preq_drop: got %b required 0", PREQ); else n_pass++;
        man_accept = 1'b0;
        wait_done(10, ok);
        n_total++; if (!ok) $display("FAIL to_done_wait: got no done, required done"); else n_pass++;
        n_total++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b required 1", timeout_err); else n_pass++;
        tick();
        n_total++; if (timeout_err !== 1'b1) $display("FAIL to_sticky_idle: got %b required 1", timeout_err); else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL to_clear: got %b required 0", timeout_err); else n_pass++;
        // Clear held across the timeout edge: the set must win, then the clear applies.
        req_valid = 1'b1;
        req_state = 1'b1;
        err_clr   = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        n_total++; if (timeout_err !== 1'b0) $display("FAIL to2_early: got %b required 0", timeout_err); else n_pass++;
        tick();
        n_total++; if (timeout_err !== 1'b1) $display("FAIL to2_set_wins: got %b required 1", timeout_err); else n_pass++;
        tick();
        n_total++; if (timeout_err !== 1'b0) $display("FAIL to2_clear_after: got %b required 0", timeout_err); else n_pass++;
        err_clr    = 1'b0;
        man_accept = 1'b1;
        push_exp(cyc + 2, 1'b1);
        tick();
        man_accept = 1'b0;
        wait_done(10, ok);
        n_total++; if (!ok) $display("FAIL to2_done_wait: got no done, required done"); else n_pass++;
    endtask

    task automatic test_idle_paccept();
        man_accept = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_total++; if (busy !== 1'b0 || PREQ !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL idle_paccept%0d: got busy=%b preq=%b ready=%b required 0/0/1", k, busy, PREQ, req_ready);
            else n_pass++;
        end
        man_accept = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_state = 1'b0;
        tick();
        req_valid = 1'b0;
        n_total++; if (PREQ !== 1'b1) $display("FAIL rmid_preq: got %b required 1", PREQ); else n_pass++;
        ARST       = 1'b1;
        man_accept = 1'b1;
        tick();
        ARST       = 1'b0;
        man_accept = 1'b0;
        n_total++; if (PREQ !== 1'b0) $display("FAIL rmid_preq_low: got %b required 0", PREQ); else n_pass++;
        n_total++; if (PSTATE !== 1'b0) $display("FAIL rmid_pstate: got %b required 0", PSTATE); else n_pass++;
        n_total++; if (cur_state !== 1'b0) $display("FAIL rmid_cur_state: got %b required 0", cur_state); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rmid_ready: got %b required 1", req_ready); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rmid_done: got %b required 0", done); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_after: got done=%b busy=%b required 0/0", done, busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        rise_dly  = 1;
        fall_dly  = 1;
        resp_en   = 1'b1;
        req_valid = 1'b1;
        req_state = 1'b1;
        tick();
        push_exp(cyc + 4, 1'b1);
        n_total++; if (PREQ !== 1'b1 || PSTATE !== 1'b1) $display("FAIL b2b_first: got preq=%b pstate=%b required 1/1", PREQ, PSTATE); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
            else if (PREQ === 1'b1) begin
                n_total++; if (PSTATE !== 1'b1) $display("FAIL b2b_stable1: got %b required 1", PSTATE); else n_pass++;
            end
        end
        n_total++; if (!ok) $display("FAIL b2b_wait1: got no done, required done"); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %b required 1", req_ready); else n_pass++;
        req_state = 1'b0;
        tick();
        req_valid = 1'b0;
        push_exp(cyc + 4, 1'b0);
        n_total++; if (PREQ !== 1'b1 || PSTATE !== 1'b0) $display("FAIL b2b_second: got preq=%b pstate=%b required 1/0", PREQ, PSTATE); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
            else if (PREQ === 1'b1) begin
                n_total++; if (PSTATE !== 1'b0) $display("FAIL b2b_stable2: got %b required 0", PSTATE); else n_pass++;
            end
        end
        n_total++; if (!ok) $display("FAIL b2b_wait2: got no done, required done"); else n_pass++;
        n_total++; if (cur_state !== 1'b0) $display("FAIL b2b_state: got %b required 0", cur_state); else n_pass++;
    endtask

    initial begin
        ARST      = 1'b1;
        req_valid = 1'b0;
        req_state = 1'b0;
        err_clr   = 1'b0;
        PACTIVE   = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        ARST = 1'b0;
        test_reset();
        test_basic_run();
        test_noop();
        test_auto_wake();
        test_timeout();
        test_idle_paccept();
        test_reset_mid();
        test_back_to_back();
        repeat (3) tick();
        n_total++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d pending transactions, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qeciphy_pchannel_ctrl.md
Name: qeciphy_pchannel_ctrl

Overview:
- P-channel initiator that drives the QECIPHY power-control inputs PSTATE and PREQ, and tracks the PACCEPT and PACTIVE responses.
- Replaces hand-driven PSTATE/PREQ with a compliant four-phase handshake sequencer on the ACLK domain.
- Adds optional auto-wake on PACTIVE, a transaction timeout monitor and a simple valid/ready request port for system software or test logic.

Parameters:
- RESET_PSTATE, 1'b0, power state assumed after reset; 1 = RUN, 0 = STOP.
- AUTO_WAKE, 1, when 1, PACTIVE high while in STOP issues an internal request to RUN.
- TIMEOUT_CYCLES, 1024, handshake cycles before timeout_err is flagged; 0 disables the timeout.

Ports:
- ACLK  in  1  clock.
- ARST  in  1  reset, synchronous, active-high.
- req_valid  in  1  request for a state change.
- req_state  in  1  target power state.
- req_ready  out  1  controller idle; a request is accepted when req_valid & req_ready.
- done  out  1  one-cycle pulse when a request completes.
- cur_state  out  1  last completed power state.
- busy  out  1  handshake in progress.
- timeout_err  out  1  sticky timeout flag.
- err_clr  in  1  clears timeout_err.
- PSTATE  out  1  to QECIPHY.
- PREQ  out  1  to QECIPHY.
- PACCEPT  in  1  from QECIPHY.
- PACTIVE  in  1  from QECIPHY.

Behaviour:
- Reset values: PREQ=0, PSTATE=RESET_PSTATE, cur_state=RESET_PSTATE, done=0, busy=0, timeout_err=0, FSM=IDLE, timeout counter=0.
- Output timing: all outputs are registered except req_ready, which is 1 exactly in IDLE.
- FSM states: IDLE, REQ, ACK.
- IDLE, external request: on accept with req_state != cur_state, the next edge sets PSTATE=req_state and PREQ=1 and moves to REQ. PSTATE changes only on this edge.
- IDLE, no-op request: on accept with req_state == cur_state, no handshake occurs; done pulses on the next cycle and the FSM stays in IDLE.
- IDLE, auto-wake: applies when AUTO_WAKE=1, cur_state=0, PACTIVE=1 and req_valid=0. The controller self-issues a request to 1 with the same timing as an external request.
- IDLE, simultaneous events: if req_valid and the auto-wake condition are both true in the same cycle, the external request wins. Auto-wake re-evaluates after done.
- REQ: PREQ is held at 1 and PSTATE is held stable. When PACCEPT=1 is sampled, the next edge sets PREQ=0 and moves to ACK. PREQ is never withdrawn before PACCEPT, even on timeout.
- ACK: PREQ=0. When PACCEPT=0 is sampled, the next edge sets cur_state=PSTATE, pulses done and returns to IDLE.
- Minimum transaction latency: accept to done is 4 cycles when PACCEPT rises 1 cycle after PREQ and falls 1 cycle after PREQ falls.
- busy: 1 in REQ and ACK.
- Timeout counter: cleared on entry to REQ; increments each cycle in REQ or ACK; saturates at TIMEOUT_CYCLES.
- Timeout flag: when the count reaches TIMEOUT_CYCLES-1 while still in REQ or ACK, timeout_err is set on the next edge. The flag is sticky.
- Timeout clear: err_clr=1 clears timeout_err on the next edge. A set and a clear in the same cycle resolve to set.
- PACCEPT=1 sampled in IDLE (protocol violation by the responder) is ignored and causes no state change.
- PACTIVE is used only for auto-wake and carries no other meaning.
- ARST mid-handshake: forces all reset values on the next edge, including PREQ=0 regardless of PACCEPT. The system must reset QECIPHY alongside.
- Widths: the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits, with a minimum of 1.

Test Plan:
- Basic RUN request: reset, then req_valid=1, req_state=1; responder raises PACCEPT 2 cycles after PREQ and drops it 1 cycle after PREQ falls. Required: PSTATE=1 with PREQ on the cycle after accept, PREQ held until PACCEPT, one done pulse, cur_state=1, busy=0, req_ready=1.
- No-op request: cur_state=1, request state 1. Required: PREQ never asserts, done pulses 1 cycle after accept, busy stays 0.
- Auto-wake: AUTO_WAKE=1, cur_state=0, PACTIVE pulses high for 1 cycle with req_valid=0. Required: full handshake to PSTATE=1. Repeat with req_valid=1, req_state=0 in the same cycle: the external request is taken as a no-op and auto-wake follows after done.
- Timeout: TIMEOUT_CYCLES=8, PACCEPT tied low. Required: timeout_err=1 exactly 8 cycles after PREQ rises; PREQ stays 1. PACCEPT is then released 1 then 0: the transaction completes and timeout_err stays 1 until err_clr.
- Reset mid-REQ: assert ARST 1 cycle while PREQ=1. Required: next cycle PREQ=0, PSTATE=RESET_PSTATE, cur_state=RESET_PSTATE, req_ready=1, no done pulse.
- Back-to-back requests: RUN then STOP, with req_valid held throughout. Required: the second request is accepted the cycle after the first done; PSTATE stays stable whenever PREQ=1; the handshake completes with cur_state=0.
